// File: rtl/sdc_pkg.sv
// Shared definitions for the SD card-detect conditioning blocks.
// One-hot debounce states and the default timing constants.
package sdc_pkg;

    typedef enum logic [3:0] {
        S_REMOVED  = 4'b0001,
        S_INS_PEND = 4'b0010,
        S_INSERTED = 4'b0100,
        S_REM_PEND = 4'b1000
    } cd_state_t;

    localparam int unsigned STABLE_CYCLES_DFLT = 500000;
    localparam int unsigned CNT_W_DFLT         = 20;
    localparam int unsigned HOLDOFF_DFLT       = 3;
    localparam bit          CD_ACTIVE_LOW_DFLT = 1'b1;

endpackage

// File: rtl/sdc_sync_2ff.sv
// Generic two-flop synchroniser for slow asynchronous pins.
// The reset value is an input so the same cell serves active-high and active-low pins.
module sdc_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic rst_val,
    output logic dout
);

    logic sync_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= rst_val;
            dout    <= rst_val;
        end else begin
            sync_p0 <= din;
            dout    <= sync_p0;
        end
    end

endmodule

// File: rtl/sdc_cd_debounce.sv
// SD card-detect conditioning: synchronise, debounce and track the card level, then
// hand single-cycle insert/remove strobes to sdc_detection while it is idle.
module sdc_cd_debounce
    import sdc_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DFLT,
    parameter int unsigned CNT_W         = CNT_W_DFLT,
    parameter bit          CD_ACTIVE_LOW = CD_ACTIVE_LOW_DFLT,
    parameter int unsigned HOLDOFF       = HOLDOFF_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic cd_raw,
    input  logic sdc_det,
    output logic card_inserted_strb,
    output logic card_removed_strb,
    output logic card_present,
    output logic evt_pending
);

    localparam int unsigned    HO_W     = $clog2(HOLDOFF + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    cd_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [HO_W-1:0]  holdoff;
    logic             sync_lvl;
    logic             cd_lvl;
    logic             pend_valid;
    logic             pend_lvl;
    logic             last_issued;
    logic             confirm;
    logic             confirm_lvl;
    logic             issue;
    logic             last_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // Stage p0/p1: pin synchronisation; flops come out of reset at the "absent" pin level
    sdc_sync_2ff u_cd_sync (
        .clk     (clk),
        .reset   (reset),
        .din     (cd_raw),
        .rst_val (CD_ACTIVE_LOW),
        .dout    (sync_lvl)
    );

    assign cd_lvl = sync_lvl ^ CD_ACTIVE_LOW;

    always_comb begin
        confirm     = 1'b0;
        confirm_lvl = 1'b0;
        if (state == S_INS_PEND && cd_lvl && cnt == CNT_LAST) begin
            confirm     = 1'b1;
            confirm_lvl = 1'b1;
        end else if (state == S_REM_PEND && !cd_lvl && cnt == CNT_LAST) begin
            confirm     = 1'b1;
            confirm_lvl = 1'b0;
        end
        issue     = pend_valid && !sdc_det && (holdoff == '0);
        // A confirmation landing on an issue edge is judged against the level just issued
        last_next = issue ? pend_lvl : last_issued;
    end

    // Stage p2: debounce FSM, pending slot and strobe issue
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_REMOVED;
            cnt                <= '0;
            card_present       <= 1'b0;
            card_inserted_strb <= 1'b0;
            card_removed_strb  <= 1'b0;
            pend_valid         <= 1'b0;
            last_issued        <= 1'b0;
            holdoff            <= '0;
        end else begin
            card_inserted_strb <= 1'b0;
            card_removed_strb  <= 1'b0;

            case (state)
                S_REMOVED: begin
                    if (cd_lvl) begin
                        state <= S_INS_PEND;
                        cnt   <= '0;
                    end
                end
                S_INS_PEND: begin
                    if (!cd_lvl) begin
                        state <= S_REMOVED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= S_INSERTED;
                        cnt          <= '0;
                        card_present <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                S_INSERTED: begin
                    if (!cd_lvl) begin
                        state <= S_REM_PEND;
                        cnt   <= '0;
                    end
                end
                S_REM_PEND: begin
                    if (cd_lvl) begin
                        state <= S_INSERTED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= S_REMOVED;
                        cnt          <= '0;
                        card_present <= 1'b0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: begin
                    state <= S_REMOVED;
                    cnt   <= '0;
                end
            endcase

            if (issue) begin
                card_inserted_strb <= pend_lvl;
                card_removed_strb  <= !pend_lvl;
                last_issued        <= pend_lvl;
                holdoff            <= HO_W'(HOLDOFF);
            end else if (holdoff != '0) begin
                holdoff <= holdoff - HO_W'(1);
            end

            // Confirming the level already reported cancels the opposite, unissued event
            if (confirm) begin
                pend_valid <= (confirm_lvl != last_next);
            end else if (issue) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (confirm) begin
            pend_lvl <= confirm_lvl;
        end
    end

    assign evt_pending = pend_valid;

endmodule

// File: doc/sdc_cd_debounce.md
Name: sdc_cd_debounce

Overview:
- Upstream conditioning stage for SD card detection.
- Synchronises the raw socket card-detect pin, debounces it with a stability timer, and tracks the debounced card level.
- Emits one-cycle card_inserted_strb / card_removed_strb pulses to sdc_detection, and only while that block is idle (sdc_det low).
- A card already present at power-up or after reset produces an insertion strobe once stable.

Parameters:
- STABLE_CYCLES, 500000, clk cycles the level must hold before it is accepted (10 ms at 50 MHz); legal range 2 .. 2^CNT_W-1.
- CNT_W, 20, stability counter width.
- CD_ACTIVE_LOW, 1, 1 = raw pin low means card present.
- HOLDOFF, 3, minimum idle cycles after any strobe before the next strobe is allowed.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high.
- cd_raw  in  1  asynchronous socket card-detect pin.
- sdc_det  in  1  downstream busy; high while sdc_detection is processing.
- card_inserted_strb  out  1  one-cycle pulse: stable insertion to report.
- card_removed_strb  out  1  one-cycle pulse: stable removal to report.
- card_present  out  1  debounced level, 1 = card present.
- evt_pending  out  1  a confirmed event is waiting to be strobed.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - FSM -> S_REMOVED; counter = 0.
  - Synchroniser flops take the "absent" pin level.
  - Outputs: card_present = 0, both strobes = 0, evt_pending = 0.
  - Internal state: last_issued = 0 (removed), holdoff counter = 0.
  - A reset mid-debounce or mid-pending discards the event.
- Synchroniser: two flops on cd_raw. cd_lvl = sync2 XOR CD_ACTIVE_LOW.
- FSM, one-hot, 4 states:
  - S_REMOVED:
    - cd_lvl = 1 -> S_INS_PEND, counter = 0.
  - S_INS_PEND:
    - cd_lvl = 0 -> S_REMOVED, counter = 0; bounce, no event.
    - Otherwise counter increments.
    - counter == STABLE_CYCLES-1 with cd_lvl = 1 -> S_INSERTED; card_present <= 1; insertion confirmed.
  - S_INSERTED:
    - cd_lvl = 0 -> S_REM_PEND, counter = 0.
  - S_REM_PEND:
    - Mirror of S_INS_PEND.
    - On confirmation -> S_REMOVED; card_present <= 0; removal confirmed.
  - Illegal encoding -> S_REMOVED, counter = 0.
- Counter: saturates at all-ones and never wraps; it is cleared on every state entry.
- Pending logic, single slot:
  - On confirmation of level L:
    - L != last_issued -> pend_valid <= 1, pend_lvl <= L.
    - L == last_issued -> pend_valid <= 0; the opposite unissued event is cancelled and nothing is strobed.
  - evt_pending = pend_valid.
- Strobe issue:
  - Condition: pend_valid AND sdc_det = 0 AND holdoff counter = 0.
  - The matching strobe is driven high for exactly 1 cycle (registered output).
  - The same edge sets last_issued <= pend_lvl, clears pend_valid, and loads the holdoff counter with HOLDOFF.
  - The holdoff counter decrements to 0. It covers the 2-cycle gap before sdc_detection raises sdc_det.
- Invariants:
  - Strobes are never simultaneous.
  - Two strobes never share a polarity back-to-back; issued events strictly alternate insert/remove, starting with insert.
- Simultaneous confirmation and issue on the same edge: issue uses the old pend state; the confirmation then updates the slot.
- Latency, unblocked: cd_raw stable change to strobe high = STABLE_CYCLES+4 clk edges (2 sync + 1 state entry + STABLE_CYCLES count + 1 issue).
- Blocked case: if sdc_det is high, the strobe is deferred. It fires on the first edge where sdc_det = 0 and holdoff = 0.

Decomposition:
- Shared package sdc_pkg: state encodings (S_REMOVED, S_INS_PEND, S_INSERTED, S_REM_PEND) and the default constants STABLE_CYCLES, HOLDOFF, CD_ACTIVE_LOW.
- Sub-module: sdc_sync_2ff (generic 2-flop synchroniser with reset value input); reused later for the write-protect pin.
- Everything else stays in one module.

Test Plan (STABLE_CYCLES = 8, HOLDOFF = 3, CD_ACTIVE_LOW = 1, sdc_det = 0 unless stated):
- Power-up present: cd_raw = 0 held through reset release -> card_inserted_strb one pulse at edge 12 after release, card_present = 1, no removal strobe.
- Bounce reject: card absent; cd_raw low 5 cycles, high 2, low 10 -> short glitch rejected; exactly one insertion strobe, 12 edges after the final low edge; card_present rises once.
- Blocked by downstream: sdc_det = 1 when insertion confirms -> evt_pending = 1, no strobe; drop sdc_det -> strobe on next edge, evt_pending = 0.
- Cancel: sdc_det = 1; insertion confirms, then removal confirms before sdc_det drops -> evt_pending returns to 0, no strobe ever issued, card_present = 0.
- Holdoff/alternation: insert then remove both confirmed while sdc_det = 1; release sdc_det -> only the net change is reported (none); repeat with last_issued = 1 -> single removal strobe, next strobe ≥ 4 cycles later.
- Reset mid-pend: assert reset during S_INS_PEND count = 5 -> all outputs 0; after release, debounce restarts from count 0.
